uart_rx_fifo: RTL and testbench

Serial receive front end of the MCU: oversamples `serial_in` at 16× baud, deframes 8N1 characters LSB-first, and queues received bytes in a small FIFO for the processor's I/O read path. It sits between the `serial_in` pin of `mcu_top_module` and the core's memory-mapped UART data/status registers. It flags framing errors and FIFO overruns.

---
 rtl/uart_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 serial receiver that queues bytes in a small first-word-fall-through FIFO.
// Flags framing errors and FIFO overruns as sticky bits.
module uart_rx_fifo #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 26,
  parameter int FIFO_AW = 2
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            serial_in,
  input  logic            rd_en,
  input  logic            err_clr,
  output logic [DBIT-1:0] rd_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun
);

  localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;

  logic            sync1;
  logic            rx_s;
  logic [CW-1:0]   tick_cnt;
  logic            tick;

  logic [DBIT-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;

  logic stop_edge;
  logic push_req;
  logic frame_set;
  logic do_pop;
  logic do_push;
  logic overrun_set;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  assign tick = (tick_cnt == CW'(DVSR - 1));

  // Start bit is re-checked at its centre; data and stop bits are sampled at their centres.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              b <= {rx_s, b[DBIT-1:1]};
              s <= '0;
              if (n == NW'(DBIT - 1)) state <= STOP;
              else                    n     <= n + NW'(1);
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == 4'(SB_TICK - 1)) state <= IDLE;
            else                      s     <= s + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_edge = (state == STOP) && tick && (s == 4'(SB_TICK - 1));
  assign push_req  = stop_edge && rx_s;
  assign frame_set = stop_edge && !rx_s;

  // The extra pointer bit separates full from empty when the index bits match.
  assign rx_empty    = (wptr == rptr);
  assign rx_full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                       (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign do_pop      = rd_en && !rx_empty;
  assign do_push     = push_req && (!rx_full || do_pop);
  assign overrun_set = push_req && rx_full && !do_pop;
  assign rd_data     = rx_empty ? '0 : mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= b;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (FIFO_AW+1)'(1);
      if (do_pop)  rptr <= rptr + (FIFO_AW+1)'(1);
    end
  end

  // A set event in the same cycle as err_clr keeps the flag asserted.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~err_clr);
      overrun   <= overrun_set | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames characters at 416 clocks/bit and checks FIFO contents,
// push-edge timing and the sticky error flags against hand-computed values.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 416;

  typedef struct packed {
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic       fe;
    logic       ov;
  } snap_t;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       serial_in = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int tc = 0;

  always #10 CLOCK = ~CLOCK;

  uart_rx_fifo #(.DBIT(8), .SB_TICK(16), .DVSR(26), .FIFO_AW(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .serial_in(serial_in), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .frame_err(frame_err), .overrun(overrun)
  );

  // Reference oversample phase: a tick edge is any posedge where tc is 25 beforehand.
  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) tc <= 0;
    else        tc <= (tc == 25) ? 0 : tc + 1;
  end

  // Drives one frame starting at a negedge; pre/post are snapshots taken just before and just
  // after the stop-bit-centre edge (152 tick edges after the start is registered).
  task automatic send_byte(input logic [7:0] d, input logic stop_val, input logic pop_at_push,
                           input int abort_at, output snap_t pre, output snap_t post);
    logic [9:0] frame;
    int ticks;
    int n_clk;
    logic push_next;
    logic line_high;
    frame = {stop_val, d, 1'b0};
    ticks = 0;
    push_next = 1'b0;
    line_high = 1'b0;
    pre = '0;
    post = '0;
    n_clk = stop_val ? 10 * BIT_CLKS : 11 * BIT_CLKS;
    if (abort_at > 0) n_clk = abort_at;
    for (int i = 0; i < n_clk; i++) begin
      @(negedge CLOCK);
      if (push_next) begin
        post = '{rd_data, rx_empty, rx_full, frame_err, overrun};
        push_next = 1'b0;
        line_high = 1'b1;
      end
      serial_in = (i / BIT_CLKS < 10 && !line_high) ? frame[i / BIT_CLKS] : 1'b1;
      if (i + 1 >= 4 && tc == 25) begin
        ticks++;
        if (ticks == 152) begin
          push_next = 1'b1;
          pre = '{rd_data, rx_empty, rx_full, frame_err, overrun};
        end
      end
      rd_en = pop_at_push && push_next;
    end
    serial_in = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic pop_byte(output logic [7:0] v);
    @(negedge CLOCK);
    v = rd_data;
    rd_en = 1'b1;
    @(negedge CLOCK);
    rd_en = 1'b0;
  endtask

  task automatic idle_clocks(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #35;
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rd_data: got %h want 00", rd_data); end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b want 1", rx_empty); end
    #5 RESET = 1'b1;
    @(negedge CLOCK);
    vectors++; if (rx_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b want 0", rx_full); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_empty: got %b want 1", rx_empty); end
  endtask

  task automatic test_receive_three();
    snap_t pre, post;
    logic [7:0] v;
    logic [7:0] exp [3];
    exp[0] = 8'h05; exp[1] = 8'h0A; exp[2] = 8'h0C;
    send_byte(8'h05, 1'b1, 1'b0, 0, pre, post);
    vectors++; if (pre.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL push_edge_pre_empty: got %b want 1", pre.empty); end
    vectors++; if (post.empty !== 1'b0) begin miscompares++; $display("[TB] FAIL push_edge_post_empty: got %b want 0", post.empty); end
    vectors++; if (post.data !== 8'h05) begin miscompares++; $display("[TB] FAIL push_edge_data: got %h want 05", post.data); end
    send_byte(8'h0A, 1'b1, 1'b0, 0, pre, post);
    send_byte(8'h0C, 1'b1, 1'b0, 0, pre, post);
    vectors++; if (rx_full !== 1'b0) begin miscompares++; $display("[TB] FAIL three_full: got %b want 0", rx_full); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (rx_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL three_empty_%0d: got %b want 0", k, rx_empty); end
      pop_byte(v);
      vectors++; if (v !== exp[k]) begin miscompares++; $display("[TB] FAIL three_pop_%0d: got %h want %h", k, v, exp[k]); end
    end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL three_drained: got %b want 1", rx_empty); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL three_rd_data_empty: got %h want 00", rd_data); end
    vectors++; if ({frame_err, overrun} !== 2'b00) begin miscompares++; $display("[TB] FAIL three_flags: got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_glitch();
    @(negedge CLOCK);
    serial_in = 1'b0;
    idle_clocks(3 * BIT_CLKS / 16);
    serial_in = 1'b1;
    idle_clocks(2 * BIT_CLKS);
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL glitch_empty: got %b want 1", rx_empty); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_frame_error();
    snap_t pre, post;
    send_byte(8'hA5, 1'b0, 1'b0, 0, pre, post);
    vectors++; if (pre.fe !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_pre: got %b want 0", pre.fe); end
    vectors++; if (post.fe !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_post: got %b want 1", post.fe); end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_nothing_pushed: got %b want 1", rx_empty); end
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_sticky: got %b want 1", frame_err); end
    @(negedge CLOCK);
    err_clr = 1'b1;
    @(negedge CLOCK);
    err_clr = 1'b0;
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_cleared: got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    snap_t pre, post;
    logic [7:0] v;
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'(k), 1'b1, 1'b0, 0, pre, post);
      vectors++; if (rx_full !== (k == 4)) begin miscompares++; $display("[TB] FAIL ovr_full_after_%0d: got %b want %b", k, rx_full, (k == 4)); end
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_before: got %b want 0", overrun); end
    send_byte(8'h05, 1'b1, 1'b0, 0, pre, post);
    vectors++; if (pre.ov !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_pre: got %b want 0", pre.ov); end
    vectors++; if (post.ov !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_post: got %b want 1", post.ov); end
    vectors++; if (post.data !== 8'h01) begin miscompares++; $display("[TB] FAIL ovr_head: got %h want 01", post.data); end
    for (int k = 1; k <= 4; k++) begin
      pop_byte(v);
      vectors++; if (v !== 8'(k)) begin miscompares++; $display("[TB] FAIL ovr_pop_%0d: got %h want %h", k, v, 8'(k)); end
    end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_drained: got %b want 1", rx_empty); end
    @(negedge CLOCK);
    err_clr = 1'b1;
    @(negedge CLOCK);
    err_clr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_cleared: got %b want 0", overrun); end
  endtask

  task automatic test_push_pop_full();
    snap_t pre, post;
    logic [7:0] v;
    logic [7:0] exp [4];
    exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'h55;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, 1'b0, 0, pre, post);
    send_byte(8'h55, 1'b1, 1'b1, 0, pre, post);
    vectors++; if (pre.full !== 1'b1) begin miscompares++; $display("[TB] FAIL pp_pre_full: got %b want 1", pre.full); end
    vectors++; if (pre.data !== 8'h01) begin miscompares++; $display("[TB] FAIL pp_pre_head: got %h want 01", pre.data); end
    vectors++; if (post.full !== 1'b1) begin miscompares++; $display("[TB] FAIL pp_post_full: got %b want 1", post.full); end
    vectors++; if (post.ov !== 1'b0) begin miscompares++; $display("[TB] FAIL pp_post_overrun: got %b want 0", post.ov); end
    vectors++; if (post.data !== 8'h02) begin miscompares++; $display("[TB] FAIL pp_post_head: got %h want 02", post.data); end
    for (int k = 0; k < 4; k++) begin
      pop_byte(v);
      vectors++; if (v !== exp[k]) begin miscompares++; $display("[TB] FAIL pp_pop_%0d: got %h want %h", k, v, exp[k]); end
    end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL pp_drained: got %b want 1", rx_empty); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL pp_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_char();
    snap_t pre, post;
    logic [7:0] v;
    send_byte(8'h3C, 1'b1, 1'b0, 5 * BIT_CLKS, pre, post);
    serial_in = 1'b0;
    RESET = 1'b0;
    serial_in = 1'b1;
    idle_clocks(2);
    RESET = 1'b1;
    @(negedge CLOCK);
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_empty: got %b want 1", rx_empty); end
    idle_clocks(BIT_CLKS);
    send_byte(8'h7E, 1'b1, 1'b0, 0, pre, post);
    vectors++; if (pre.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_pre_empty: got %b want 1", pre.empty); end
    vectors++; if (post.data !== 8'h7E) begin miscompares++; $display("[TB] FAIL rst_mid_head: got %h want 7e", post.data); end
    pop_byte(v);
    vectors++; if (v !== 8'h7E) begin miscompares++; $display("[TB] FAIL rst_mid_pop: got %h want 7e", v); end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_only_one: got %b want 1", rx_empty); end
    vectors++; if ({frame_err, overrun} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_mid_flags: got %b want 00", {frame_err, overrun}); end
  endtask

  initial begin
    test_reset();
    test_receive_three();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_push_pop_full();
    test_reset_mid_char();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge CLOCK);
    $display("[TB] FAIL watchdog: reached 95000 cycles, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
